count_sort_reader: RTL and testbench

- Read-out end of the counting-sort datapath: consumes a per-bin count table (histogram) and streams the sorted values over a valid/ready read interface.
- The upstream block, or the testbench, writes MAX bin counts in bin order 0..MAX-1 on the write channel.
- The block then emits each bin index as many times as its count, ascending, and marks the final element.
- Sits downstream of the histogram/prefix stage and feeds the sorted-data consumer.

---
 rtl/count_sort_reader.sv | 147 ++++++++++++++
 tb/tb_count_sort_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sort_reader.sv
// count_sort_reader: read-out end of the counting-sort datapath.
// Loads MAX bin counts (bin 0 first), then streams every bin index as many
// times as its count over a valid/ready read channel. The final element is
// flagged with read_last_o.
// Optional macro COUNT_SORT_DESC_EN: scan bins from MAX-1 down to 0, which
// gives a descending stream. The load order is unchanged.
module count_sort_reader #(
  parameter int DATA_WIDTH = 5,
  parameter int DATA_SIZE  = 4,
  parameter int MAX        = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_SIZE) + 1,
  parameter int TOT_WIDTH  = CNT_WIDTH + $clog2(MAX)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_valid_i,
  output logic                  write_ready_o,
  input  logic [CNT_WIDTH-1:0]  write_data_i,
  input  logic                  read_ready_i,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  read_last_o,
  output logic                  busy_o
);

  localparam int IDX_W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [IDX_W-1:0] FIRST_BIN = '0;
  localparam logic [IDX_W-1:0] LAST_BIN  = IDX_W'(MAX - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [TOT_WIDTH-1:0] TOT_ONE = TOT_WIDTH'(1);
  localparam logic [TOT_WIDTH-1:0] TOT_TWO = TOT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

`ifdef COUNT_SORT_DESC_EN
  localparam logic [IDX_W-1:0] SCAN_START = LAST_BIN;
  localparam logic [IDX_W-1:0] SCAN_END   = FIRST_BIN;
`else
  localparam logic [IDX_W-1:0] SCAN_START = FIRST_BIN;
  localparam logic [IDX_W-1:0] SCAN_END   = LAST_BIN;
`endif

  // Step to the next bin in scan order.
  function automatic logic [IDX_W-1:0] scan_step(input logic [IDX_W-1:0] i);
`ifdef COUNT_SORT_DESC_EN
    return i - IDX_ONE;
`else
    return i + IDX_ONE;
`endif
  endfunction

  typedef enum logic [1:0] {
    S_LOAD,
    S_SCAN,
    S_EMIT
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [TOT_WIDTH-1:0] total;
  logic [CNT_WIDTH-1:0] bin_cnt [MAX];
  logic [CNT_WIDTH-1:0] cur_cnt;

  // Count of the bin currently addressed by idx.
  assign cur_cnt = bin_cnt[idx];

  // Control FSM, count table and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_LOAD;
      idx           <= '0;
      total         <= '0;
      for (int i = 0; i < MAX; i++) begin
        bin_cnt[i] <= '0;
      end
      write_ready_o <= 1'b1;
      read_valid_o  <= 1'b0;
      read_data_o   <= '0;
      read_last_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          // write_ready_o is high throughout LOAD, so valid alone is a transfer.
          if (write_valid_i) begin
            bin_cnt[idx] <= write_data_i;
            total        <= total + TOT_WIDTH'(write_data_i);
            if (idx == LAST_BIN) begin
              idx           <= SCAN_START;
              state         <= S_SCAN;
              write_ready_o <= 1'b0;
              busy_o        <= 1'b1;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end

        S_SCAN: begin
          if (cur_cnt != '0) begin
            state        <= S_EMIT;
            read_valid_o <= 1'b1;
            read_data_o  <= DATA_WIDTH'(idx);
            read_last_o  <= (total == TOT_ONE);
          end else if (idx == SCAN_END) begin
            // Empty table: nothing to emit, go straight back to loading.
            idx           <= '0;
            total         <= '0;
            state         <= S_LOAD;
            write_ready_o <= 1'b1;
            busy_o        <= 1'b0;
          end else begin
            idx <= scan_step(idx);
          end
        end

        S_EMIT: begin
          // Outputs hold while the consumer stalls.
          if (read_ready_i) begin
            bin_cnt[idx] <= cur_cnt - CNT_ONE;
            total        <= total - TOT_ONE;
            if (cur_cnt != CNT_ONE) begin
              // Same bin again next cycle, no bubble.
              read_last_o <= (total == TOT_TWO);
            end else if (total == TOT_ONE) begin
              idx           <= '0;
              state         <= S_LOAD;
              read_valid_o  <= 1'b0;
              read_last_o   <= 1'b0;
              write_ready_o <= 1'b1;
              busy_o        <= 1'b0;
            end else begin
              idx          <= scan_step(idx);
              state        <= S_SCAN;
              read_valid_o <= 1'b0;
              read_last_o  <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sort_reader.sv
// Testbench for count_sort_reader (MAX=8, DATA_WIDTH=3). Stimulus pushes the
// expected sorted stream into a queue; a monitor pops and compares on each
// read transfer and checks that stalled outputs stay stable.
module tb_count_sort_reader;

  localparam int M  = 8;
  localparam int DW = 3;
  localparam int DS = 4;
  localparam int CW = $clog2(DS) + 1;
  localparam int TW = CW + $clog2(M);

  logic          clk = 1'b0;
  logic          rst_i;
  logic          write_valid_i;
  logic          write_ready_o;
  logic [CW-1:0] write_data_i;
  logic          read_ready_i;
  logic          read_valid_o;
  logic [DW-1:0] read_data_o;
  logic          read_last_o;
  logic          busy_o;

  int tot = 0;
  int bad = 0;
  int exp_q[$];
  int tbl[M];
  int rmode = 0;

  count_sort_reader #(
    .DATA_WIDTH(DW),
    .DATA_SIZE (DS),
    .MAX       (M),
    .CNT_WIDTH (CW),
    .TOT_WIDTH (TW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .write_valid_i(write_valid_i),
    .write_ready_o(write_ready_o),
    .write_data_i (write_data_i),
    .read_ready_i (read_ready_i),
    .read_valid_o (read_valid_o),
    .read_data_o  (read_data_o),
    .read_last_o  (read_last_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tot++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", nm, got, want, $time);
    end
  endtask

  // Reference: sorted list is each bin value repeated by its count.
  task automatic push_expected();
    int n = 0;
    int k = 0;
    int order[$];
    for (int i = 0; i < M; i++) n += tbl[i];
`ifdef COUNT_SORT_DESC_EN
    for (int v = M - 1; v >= 0; v--) for (int r = 0; r < tbl[v]; r++) order.push_back(v);
`else
    for (int v = 0; v < M; v++) for (int r = 0; r < tbl[v]; r++) order.push_back(v);
`endif
    foreach (order[j]) begin
      k++;
      exp_q.push_back((order[j] << 1) | ((k == n) ? 1 : 0));
    end
  endtask

  task automatic load_tbl(input bit gaps);
    push_expected();
    for (int i = 0; i < M; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        write_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      write_valid_i = 1'b1;
      write_data_i  = CW'(tbl[i]);
      chk("write_ready_in_load", write_ready_o, 1);
      @(posedge clk); #1;
    end
    write_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int c = 0;
    while (!(exp_q.size() == 0 && write_ready_o === 1'b1) && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    chk({nm, "_drain_in_time"}, (c < 400) ? 1 : 0, 1);
    chk({nm, "_idle_valid"}, read_valid_o, 0);
    chk({nm, "_idle_busy"}, busy_o, 0);
    chk({nm, "_idle_wready"}, write_ready_o, 1);
  endtask

  task automatic wait_valid(input string nm);
    int c = 0;
    while (read_valid_o !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_valid_seen"}, (c < 100) ? 1 : 0, 1);
  endtask

  task automatic set_tbl(input int a0, a1, a2, a3, a4, a5, a6, a7);
    tbl[0] = a0; tbl[1] = a1; tbl[2] = a2; tbl[3] = a3;
    tbl[4] = a4; tbl[5] = a5; tbl[6] = a6; tbl[7] = a7;
  endtask

  // Consumer ready driver.
  initial begin
    int ph = 0;
    read_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: read_ready_i = 1'b1;
        1: begin
          read_ready_i = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: read_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor.
  initial begin
    bit   stall_prev = 0;
    bit   rst_prev = 1;
    int   prev_word = 0;
    int   e;
    forever begin
      @(negedge clk);
      if (rst_i !== 1'b1) begin
        if (stall_prev && !rst_prev) begin
          chk("stall_valid_held", read_valid_o, 1);
          chk("stall_output_held", {read_data_o, read_last_o}, prev_word);
        end
        if (read_valid_o === 1'b1 && read_ready_i === 1'b1) begin
          if (exp_q.size() == 0) begin
            tot++;
            bad++;
            $display("FAIL unexpected_output: got data=%0d last=%0d expected no element",
                     read_data_o, read_last_o);
          end else begin
            e = exp_q.pop_front();
            chk("stream_data", read_data_o, e >> 1);
            chk("stream_last", read_last_o, e & 1);
          end
        end
      end
      stall_prev = (read_valid_o === 1'b1) && (read_ready_i === 1'b0) && (rst_i === 1'b0);
      prev_word  = {read_data_o, read_last_o};
      rst_prev   = (rst_i === 1'b1);
    end
  end

  initial begin
    rst_i         = 1'b1;
    write_valid_i = 1'b0;
    write_data_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("reset_wready", write_ready_o, 1);
    chk("reset_rvalid", read_valid_o, 0);
    chk("reset_rdata", read_data_o, 0);
    chk("reset_rlast", read_last_o, 0);
    chk("reset_busy", busy_o, 0);

    // Basic table, always ready.
    rmode = 0;
    set_tbl(0, 2, 0, 1, 0, 0, 0, 1);
    load_tbl(1'b0);
    chk("scan_busy", busy_o, 1);
    chk("scan_wready_low", write_ready_o, 0);
    wait_drain("basic");

    // Same table with a stalling consumer.
    rmode = 1;
    set_tbl(0, 2, 0, 1, 0, 0, 0, 1);
    load_tbl(1'b1);
    wait_drain("stall");

    // All-zero table: back to LOAD exactly M cycles after the last write.
    rmode = 0;
    set_tbl(0, 0, 0, 0, 0, 0, 0, 0);
    load_tbl(1'b0);
    for (int c = 1; c <= M; c++) begin
      @(posedge clk); #1;
      if (c == M - 1) chk("zero_wready_before", write_ready_o, 0);
      if (c == M) chk("zero_wready_after", write_ready_o, 1);
      chk("zero_no_valid", read_valid_o, 0);
    end
    wait_drain("zero");

    // Single bin with count 4: four back-to-back elements.
    set_tbl(0, 0, 0, 0, 0, 4, 0, 0);
    load_tbl(1'b0);
    @(negedge clk);
    wait_valid("single");
    for (int k = 0; k < 4; k++) begin
      chk("single_no_bubble", read_valid_o, 1);
      chk("single_data", read_data_o, 5);
      chk("single_last", read_last_o, (k == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("single_end_valid", read_valid_o, 0);
    wait_drain("single");

    // Reset during EMIT after the first element.
    set_tbl(0, 2, 0, 1, 0, 0, 0, 1);
    load_tbl(1'b0);
    @(negedge clk);
    wait_valid("abort");
    @(posedge clk); #1;
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("abort_rvalid", read_valid_o, 0);
    chk("abort_wready", write_ready_o, 1);
    chk("abort_busy", busy_o, 0);
    set_tbl(1, 0, 0, 0, 0, 0, 0, 0);
    load_tbl(1'b0);
    wait_drain("abort_reload");

    // Randomized tables with random consumer stalls.
    rmode = 2;
    for (int t = 0; t < 25; t++) begin
      int n;
      for (int i = 0; i < M; i++) tbl[i] = 0;
      n = $urandom_range(0, DS);
      repeat (n) tbl[$urandom_range(0, M - 1)]++;
      load_tbl(1'b1);
      wait_drain("random");
    end

    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", tot, bad);
    $fatal(1, "timeout");
  end

endmodule
